// File: rtl/g05_pkg.sv
// rtl/g05_pkg.sv - shared state encoding and defaults for the serial equality checker
package g05_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/bit_eq_nor.sv
// rtl/bit_eq_nor.sv - one-bit equality (XNOR) built from four NOR gates
module bit_eq_nor (
   input  logic x,
   input  logic y,
   output logic eq
);

   wire n_xy;
   wire n_x;
   wire n_y;

   // n_x / n_y are high only for the two unequal input pairs
   nor g_xy (n_xy, x, y);
   nor g_x  (n_x, x, n_xy);
   nor g_y  (n_y, y, n_xy);
   nor g_eq (eq, n_x, n_y);

endmodule

// File: rtl/serial_eq_checker.sv
// rtl/serial_eq_checker.sv - word-level verdict over two LSB-first serial bit streams
module serial_eq_checker
   import g05_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = $clog2(WIDTH + 1),
   parameter int IW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          bit_valid,
   input  logic          x,
   input  logic          y,
   output logic          busy,
   output logic          done,
   output logic          equal,
   output logic [CW-1:0] mismatch_cnt,
   output logic [IW-1:0] first_mm_idx
);

   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   state_t        state;
   logic [IW-1:0] idx;
   logic          seen;
   logic          eq;
   logic [CW-1:0] cnt_next;

   bit_eq_nor u_bit_eq (
      .x  (x),
      .y  (y),
      .eq (eq)
   );

   assign cnt_next = mismatch_cnt + {{(CW-1){1'b0}}, ~eq};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         equal        <= 1'b0;
         mismatch_cnt <= '0;
         first_mm_idx <= '0;
         idx          <= '0;
         seen         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_RUN;
                  busy         <= 1'b1;
                  idx          <= '0;
                  mismatch_cnt <= '0;
                  first_mm_idx <= '0;
                  seen         <= 1'b0;
               end
            end
            S_RUN: begin
               if (bit_valid) begin
                  if (!eq) begin
                     mismatch_cnt <= cnt_next;
                     if (!seen) begin
                        first_mm_idx <= idx;
                        seen         <= 1'b1;
                     end
                  end
                  if (idx == LAST_IDX) begin
                     // verdict uses the count including the bit sampled now
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     equal <= (cnt_next == '0);
                     idx   <= '0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
